// File: rtl/demux3_collect.sv
// Rebuilds a parallel (a, b, c) triple from a lane-tagged word stream and holds it
// under valid/ready until the consumer takes it.
//
// state     | meaning
// S_COLLECT | gathering words into lanes; in_ready = 1, out_valid = 0
// S_HOLD    | full triple presented; in_ready follows out_ready
module demux3_collect #(
  parameter int INT_LENGTH  = 5,
  parameter int FRAC_LENGTH = 12,
  localparam int W = INT_LENGTH + FRAC_LENGTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [1:0]   in_sel,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic         dup_err
);

  typedef enum logic {S_COLLECT = 1'b0, S_HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [2:0]     fm_q, fm_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic           out_valid_q, out_valid_d;
  logic           dup_err_q, dup_err_d;

  logic           acc;
  logic           xfer;
  logic [2:0]     fm_base;
  logic [2:0]     lane_bit;

  assign in_ready  = (state_q == S_COLLECT) | out_ready;
  assign out_valid = out_valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign dup_err   = dup_err_q;

  always_comb begin
    acc         = in_valid & in_ready;
    xfer        = out_valid_q & out_ready;
    // A transfer frees the triple, so a same-cycle word starts from an empty mask.
    fm_base     = xfer ? 3'b000 : fm_q;
    lane_bit    = 3'b000;
    if (acc && (in_sel != 2'b11))
      lane_bit = 3'b001 << in_sel;
    fm_d        = fm_base | lane_bit;
    dup_err_d   = |(fm_base & lane_bit);
    a_d         = lane_bit[0] ? in_data : a_q;
    b_d         = lane_bit[1] ? in_data : b_q;
    c_d         = lane_bit[2] ? in_data : c_q;
    state_d     = (fm_d == 3'b111) ? S_HOLD : S_COLLECT;
    out_valid_d = (fm_d == 3'b111);
    if (flush) begin
      fm_d        = 3'b000;
      dup_err_d   = 1'b0;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      state_d     = S_COLLECT;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      fm_q        <= 3'b000;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fm_q        <= fm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      dup_err_q   <= dup_err_d;
    end
  end

endmodule

// File: tb/tb_demux3_collect.sv
// Directed bench for demux3_collect: fill orders, discard, duplicates,
// back-pressure, flush and asynchronous reset.
module tb_demux3_collect;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   in_sel;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_b, out_c;
  logic         dup_err;

  int n_vec = 0;
  int n_err = 0;

  demux3_collect #(.INT_LENGTH(5), .FRAC_LENGTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [W-1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_triple(input string tag, input logic [W-1:0] ea,
                            input logic [W-1:0] eb, input logic [W-1:0] ec);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".a"}, out_a, ea);
    chk({tag, ".b"}, out_b, eb);
    chk({tag, ".c"}, out_c, ec);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst.valid", out_valid, 0);
    chk("rst.a", out_a, 0);
    chk("rst.dup", dup_err, 0);
    chk("rst.ready", in_ready, 1);
    #1 rst_n = 1'b1;

    // in-order fill
    send(2'b00, 17'h00001);
    chk("fill1.valid", out_valid, 0);
    send(2'b01, 17'h1F000);
    chk("fill2.valid", out_valid, 0);
    send(2'b10, 17'h0ABCD);
    chk_triple("fill", 17'h00001, 17'h1F000, 17'h0ABCD);
    tick();
    chk("fill.consumed", out_valid, 0);

    // out-of-order with a discarded word
    send(2'b10, 17'd5);
    chk("ooo1.dup", dup_err, 0);
    send(2'b11, 17'd7);
    chk("ooo2.valid", out_valid, 0);
    chk("ooo2.dup", dup_err, 0);
    send(2'b00, 17'd1);
    chk("ooo3.valid", out_valid, 0);
    send(2'b01, 17'd2);
    chk_triple("ooo", 17'd1, 17'd2, 17'd5);
    chk("ooo4.dup", dup_err, 0);
    tick();
    chk("ooo.consumed", out_valid, 0);

    // duplicate lane, last write wins
    send(2'b00, 17'd3);
    chk("dup1.dup", dup_err, 0);
    send(2'b00, 17'd4);
    chk("dup2.dup", dup_err, 1);
    send(2'b01, 17'd8);
    chk("dup3.dup", dup_err, 0);
    send(2'b10, 17'd9);
    chk_triple("dup", 17'd4, 17'd8, 17'd9);
    tick();
    chk("dup.consumed", out_valid, 0);

    // back-pressure with a word waiting upstream
    out_ready = 1'b0;
    send(2'b00, 17'd10);
    send(2'b01, 17'd11);
    send(2'b10, 17'd12);
    chk_triple("bp", 17'd10, 17'd11, 17'd12);
    in_valid = 1'b1;
    in_sel   = 2'b00;
    in_data  = 17'd6;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.stall_ready", in_ready, 0);
      tick();
      chk("bp.stall_valid", out_valid, 1);
      chk("bp.stall_a", out_a, 17'd10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ready_follows", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp.release_valid", out_valid, 0);
    chk("bp.release_dup", dup_err, 0);
    send(2'b01, 17'd13);
    chk("bp.fm001", out_valid, 0);
    send(2'b10, 17'd14);
    chk_triple("bp.next", 17'd6, 17'd13, 17'd14);
    tick();
    chk("bp.consumed", out_valid, 0);

    // flush with a partial triple, simultaneous word dropped
    send(2'b00, 17'd20);
    send(2'b01, 17'd21);
    flush = 1'b1;
    send(2'b10, 17'd50);
    flush = 1'b0;
    chk("fl1.valid", out_valid, 0);
    chk("fl1.dup", dup_err, 0);
    send(2'b10, 17'd22);
    chk("fl1.needs_all", out_valid, 0);
    send(2'b00, 17'd23);
    chk("fl1.needs_b", out_valid, 0);
    send(2'b01, 17'd24);
    chk_triple("fl1", 17'd23, 17'd24, 17'd22);

    // flush while holding
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl2.valid", out_valid, 0);
    chk("fl2.a_kept", out_a, 17'd23);
    send(2'b01, 17'd31);
    send(2'b10, 17'd32);
    chk("fl2.needs_a", out_valid, 0);
    send(2'b00, 17'd33);
    chk_triple("fl2", 17'd33, 17'd31, 17'd32);

    // asynchronous reset while holding
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", out_valid, 0);
    chk("arst.a", out_a, 0);
    chk("arst.b", out_b, 0);
    chk("arst.c", out_c, 0);
    chk("arst.dup", dup_err, 0);
    chk("arst.ready", in_ready, 1);
    #3 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux3_collect.md
# demux3_collect

Sequential inverse of the team's 3-to-1 fixed-point selector: accepts a single tagged stream of Q(INT_LENGTH.FRAC_LENGTH) words and rebuilds the parallel triple (a, b, c). It sits between the serialised datapath in the QR matrix-inversion engine and the stages that consume three operands at once. It holds the assembled triple under a valid/ready handshake and applies back-pressure while the triple is unconsumed.

## Interface
- INT_LENGTH, 5, integer bits of each word
- FRAC_LENGTH, 12, fractional bits of each word; word width W = INT_LENGTH+FRAC_LENGTH (17)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word present
- in_sel  input  2  lane tag of the input word, as follows:
  - 00 → a
  - 01 → b
  - 10 → c
  - 11 → discard
- in_data  input  W  input word
- in_ready  output  1  block can accept a word this cycle
- flush  input  1  synchronous clear of the partial and held triple
- out_valid  output  1  assembled triple is valid
- out_ready  input  1  downstream accepts the triple
- out_a, out_b, out_c  output  W  assembled triple, registered
- dup_err  output  1  one-cycle pulse: the accepted word targeted an already-filled lane

## Operation
- Input accept: in_valid & in_ready at a rising edge.
- Output transfer: out_valid & out_ready at a rising edge.
- Internal fill mask fm[2:0] records which lanes hold a word in the current triple. Bit 0 = a, bit 1 = b, bit 2 = c.
- COLLECT state, entered after reset:
  - out_valid = 0.
  - in_ready = 1.
  - An accepted word with sel 00, 01 or 10 writes in_data into the lane register and sets the matching fm bit.
  - sel 11: the word is accepted and dropped; no state change and no dup_err.
  - Accepted word to a lane whose fm bit is already set: the lane is overwritten (last write wins) and dup_err pulses.
  - When the accept makes fm = 111, the next state is HOLD.
- HOLD state:
  - out_valid = 1.
  - out_a/b/c are stable until the output transfer.
  - in_ready = out_ready (combinational; no other path from out_ready to outputs).
- Output transfer in HOLD:
  - fm clears and the state returns to COLLECT.
  - If an input accept occurs in the same cycle, that word starts the new triple: fm becomes the single bit for its lane, or 000 for sel 11.
  - The state goes straight back to HOLD only when fm would be 111, which is impossible from one word, so the next state is COLLECT.
- Lane registers are not cleared between triples; consumers use out_a/b/c only while out_valid = 1.
- flush = 1 at an edge, in any state:
  - fm ← 000, state ← COLLECT, out_valid ← 0.
  - A simultaneous input word is discarded, no dup_err.
  - Lane registers keep their values.
  - flush has priority over every other event.
- No arithmetic: words pass through bit-exact with width W; no sign extension or rounding.

## Timing
- Reset (rst_n low, asynchronous):
  - state COLLECT, fm 000
  - out_valid 0
  - out_a/b/c all zero
  - dup_err 0
  - in_ready therefore reads 1
- Latency: the word completing the triple is accepted at edge N; out_valid and the new out_a/b/c are visible after edge N. One cycle, fully registered.
- dup_err is registered: high for exactly the one cycle following the offending accept edge.
- Throughput: one word per cycle; a triple every 3 cycles when out_ready is held high. The HOLD cycle overlaps the first word of the next triple.
- Reset asserted mid-collection or in HOLD: the partial/held triple is lost immediately; out_valid falls without waiting for a clock.

## Test plan
- Reset then in-order fill:
  - Stimulus: sel 00/01/10 with data 17'h00001, 17'h1F000, 17'h0ABCD on 3 consecutive cycles; out_ready = 1.
  - Response: out_valid high for exactly 1 cycle starting after the 3rd edge, with out_a=00001, out_b=1F000, out_c=0ABCD.
- Out-of-order with discard:
  - Stimulus: sel 10 (5), then 11 (7), then 00 (1), then 01 (2).
  - Response: triple a=1, b=2, c=5 after the 4th word; the value 7 never appears; dup_err stays 0.
- Duplicate lane:
  - Stimulus: sel 00 (3), then 00 (4), then 01 (8), then 10 (9).
  - Response: dup_err high for one cycle after the 2nd word; the triple is a=4, b=8, c=9.
- Back-pressure:
  - Stimulus: complete a triple while out_ready = 0 for 5 cycles, with in_valid held high and sel 00 (6).
  - Response during the stall: in_ready = 0, outputs stable, no word lost.
  - Then raise out_ready: the transfer and the accept of 6 happen on the same edge; the next state is COLLECT with fm=001 and out_valid=0.
- Flush and async reset:
  - Flush stimulus: flush with fm=011, later flush in HOLD.
  - Flush response: out_valid 0 after the edge; the next triple needs all 3 lanes again.
  - Reset stimulus: pull rst_n low between edges while in HOLD.
  - Reset response: out_valid, out_a/b/c and dup_err go to 0 immediately, without a clock edge.
